// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared definitions for the UART transmitter arbiter.
//   arb_state_e            - arbiter FSM state encoding (2 bits)
//   DEFAULT_TIMEOUT_CYCLES - default watchdog limit when the timeout is built in
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no owner
        ST_SEND = 2'd1,   // first byte of a fresh grant is issued on exit
        ST_WAIT = 2'd2,   // byte in flight, waiting for Done
        ST_GAP  = 2'd3    // transmitter cleanup cycle, then continue or re-arbitrate
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16384;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   i_Req        - request vector
//   i_Last_Owner - index of the previous owner; search starts one above it
//   o_Win        - one-hot winner (zero when nobody requests)
//   o_Any        - at least one request present
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_Req,
    input  logic [$clog2(NUM_REQ)-1:0] i_Last_Owner,
    output logic [NUM_REQ-1:0]         o_Win,
    output logic                       o_Any
);

    logic found;

    // Walk the ring starting at last_owner+1; the previous owner is checked last.
    always_comb begin
        o_Win = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && i_Req[(int'(i_Last_Owner) + off) % NUM_REQ]) begin
                o_Win[(int'(i_Last_Owner) + off) % NUM_REQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign o_Any = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_TX between NUM_REQ message sources.
// A source keeps the grant for a whole message, byte by byte, until it flags
// the last byte or drops its request. All outputs are registered.
//   i_Clock, i_Reset_n        - clock, async active-low reset
//   i_Req/i_Byte/i_Last       - per-source request, byte (8 bits each), last flag
//   o_Ack                     - per-source pulse when its byte is taken
//   o_Grant                   - one-hot owner, zero when free
//   o_TX_DV/o_TX_Byte         - to UART_TX
//   i_TX_Active/i_TX_Done     - from UART_TX
//   o_Timeout                 - watchdog abort pulse
// Build option: define UART_TX_ARB_TIMEOUT_EN to add the WAIT watchdog
// (TIMEOUT_CYCLES clocks); otherwise o_Timeout stays 0.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Byte,
    input  logic [NUM_REQ-1:0]   i_Last,
    output logic [NUM_REQ-1:0]   o_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done,
    output logic                 o_Timeout
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d, win;
    logic [IW-1:0]      owner_q, owner_d, last_owner_q, last_owner_d, pick_last, win_idx;
    logic               last_q, last_d, dv_q, dv_d, tmo_q, tmo_d;
    logic [7:0]         byte_q, byte_d, owner_byte;
    logic               any_req, owner_req, owner_last;
    logic               gap_ok, gap_release, gap_continue, issue, timeout_hit;

    assign owner_req  = i_Req[owner_q];
    assign owner_last = i_Last[owner_q];
    assign owner_byte = i_Byte[{owner_q, 3'b000} +: 8];

    assign gap_ok       = (state_q == ST_GAP) && !i_TX_Active;
    assign gap_release  = gap_ok && (last_q || !owner_req);
    assign gap_continue = gap_ok && !gap_release;
    // A continuing owner already holds the grant, so its next byte is issued
    // straight out of GAP; this puts DV two cycles after Done.
    assign issue        = (state_q == ST_SEND) || gap_continue;

    // On release the contest starts after the owner being released.
    assign pick_last = gap_release ? owner_q : last_owner_q;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_Req        (i_Req),
        .i_Last_Owner (pick_last),
        .o_Win        (win),
        .o_Any        (any_req)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = IW'(i);
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_q, wd_d;

    assign wd_d        = (state_q == ST_WAIT) ? wd_q + CW'(1) : '0;
    // wd_q counts completed WAIT cycles; the last allowed one aborts.
    assign timeout_hit = (state_q == ST_WAIT) && !i_TX_Done &&
                         (wd_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) wd_q <= '0;
        else            wd_q <= wd_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_TX_Done)        state_d = ST_GAP;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_release)       state_d = any_req ? ST_SEND : ST_IDLE;
                else if (gap_continue) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        last_d       = last_q;
        byte_d       = byte_q;
        dv_d         = 1'b0;
        ack_d        = '0;
        tmo_d        = timeout_hit;
        if (gap_release || timeout_hit) begin
            grant_d      = '0;
            last_owner_d = owner_q;
        end
        if (((state_q == ST_IDLE) || gap_release) && any_req) begin
            grant_d = win;
            owner_d = win_idx;
        end
        if (issue) begin
            dv_d   = 1'b1;
            ack_d  = grant_q;
            byte_d = owner_byte;
            last_d = owner_last;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(NUM_REQ - 1);
            last_q       <= 1'b0;
            byte_q       <= 8'h00;
            dv_q         <= 1'b0;
            ack_q        <= '0;
            tmo_q        <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            last_q       <= last_d;
            byte_q       <= byte_d;
            dv_q         <= dv_d;
            ack_q        <= ack_d;
            tmo_q        <= tmo_d;
        end
    end

    assign o_Grant   = grant_q;
    assign o_Ack     = ack_q;
    assign o_TX_DV   = dv_q;
    assign o_TX_Byte = byte_q;
    assign o_Timeout = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a simple
// UART_TX model (Done 10 cycles after DV). Expected {source, byte} pairs are
// queued in the required transmit order when messages are loaded and popped
// at each DV. Timeout scenario runs when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N        = 2;
    localparam int DONE_LAT = 10;
    localparam int TMO      = 100;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req, last, ack, grant;
    logic [8*N-1:0] bytes;
    logic           dv, tmo;
    logic           tx_active = 1'b0, tx_done = 1'b0;
    logic [7:0]     tx_byte;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Req       (req),
        .i_Byte      (bytes),
        .i_Last      (last),
        .o_Ack       (ack),
        .o_Grant     (grant),
        .o_TX_DV     (dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done),
        .o_Timeout   (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // UART_TX model
    int rem = 0;
    bit withhold = 1'b0;
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (dv) begin
            tx_active <= 1'b1;
            rem       <= DONE_LAT - 1;
        end else if (rem == 1 && !withhold) begin
            tx_done   <= 1'b1;
            tx_active <= 1'b0;
            rem       <= 0;
        end else if (rem > 1) begin
            rem <= rem - 1;
        end
    end

    // Sources: per-source byte/last queues, front entry is presented
    logic [7:0]  bq[N][$];
    bit          lq[N][$];
    logic [15:0] exp_q[$];

    task automatic present();
        for (int k = 0; k < N; k++) begin
            req[k]           = (bq[k].size() > 0);
            bytes[8*k +: 8]  = (bq[k].size() > 0) ? bq[k][0] : 8'h00;
            last[k]          = (lq[k].size() > 0) ? lq[k][0] : 1'b0;
        end
    endtask

    task automatic send(input int src, input logic [7:0] b, input bit lst);
        bq[src].push_back(b);
        lq[src].push_back(lst);
        exp_q.push_back({8'(src), b});
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (ack[k] && bq[k].size() > 0) begin
                void'(bq[k].pop_front());
                void'(lq[k].pop_front());
            end
        end
        present();
    end

    // Monitor: scoreboard compare at DV, Done-to-DV spacing within busy runs
    int          n_dv = 0, n_tmo = 0, last_dv_cyc = 0, last_done_cyc = 0, prev_src = -1;
    bit          pend_gap = 1'b0;
    logic [15:0] mon_e;
    always @(negedge clk) begin
        if (dv) begin
            n_dv++;
            last_dv_cyc = cyc;
            mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
            chk("dv_byte",  32'(tx_byte), 32'(mon_e[7:0]));
            chk("dv_grant", 32'(grant), 32'(1) << mon_e[15:8]);
            chk("dv_ack",   32'(ack),   32'(1) << mon_e[15:8]);
            if (pend_gap)
                chk("dv_gap", cyc - last_done_cyc, (int'(mon_e[15:8]) == prev_src) ? 2 : 3);
            prev_src = int'(mon_e[15:8]);
            pend_gap = 1'b0;
        end
        if (tmo) n_tmo++;
        if (grant == '0) pend_gap = 1'b0;
        else if (tx_done) begin
            pend_gap      = 1'b1;
            last_done_cyc = cyc;
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || grant != '0 || bq[0].size() != 0 || bq[1].size() != 0)
               && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 0);
        chk({tag, "_released"}, 32'(grant), 0);
    endtask

    initial begin
        int d0, t;
        present();
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_dv",    32'(dv), 0);
        chk("rst_byte",  32'(tx_byte), 0);
        chk("rst_ack",   32'(ack), 0);
        rst_n = 1'b1;

        // single source "A\r\n"
        @(negedge clk);
        send(0, 8'h41, 1'b0); send(0, 8'h0D, 1'b0); send(0, 8'h0A, 1'b1); present();
        @(negedge clk); chk("lat_grant", 32'(grant), 1);
        chk("lat_dv_early", 32'(dv), 0);
        @(negedge clk); chk("lat_dv", 32'(dv), 1);
        wait_drain("single", 200);
        chk("single_dvs", n_dv, 3);

        // reset during WAIT
        @(negedge clk);
        send(0, 8'h58, 1'b0); send(0, 8'h59, 1'b1); present();
        d0 = n_dv; t = 0;
        while (n_dv == d0 && t < 50) begin @(negedge clk); t++; end
        chk("rst_first_dv", n_dv, d0 + 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_byte",  32'(tx_byte), 0);
        chk("arst_dv",    32'(dv), 0);
        chk("arst_ack",   32'(ack), 0);
        chk("arst_tmo",   32'(tmo), 0);
        bq[0].delete(); lq[0].delete(); exp_q.delete(); present();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        d0 = n_dv;
        repeat (20) @(negedge clk);
        chk("rst_no_dv", n_dv, d0);
        send(1, 8'h5A, 1'b1); present();
        wait_drain("post_rst", 100);

        // contention: source 0 (2 bytes) wholly before source 1 (3 bytes)
        @(negedge clk);
        send(0, 8'hC0, 1'b0); send(0, 8'hC1, 1'b1);
        send(1, 8'hD0, 1'b0); send(1, 8'hD1, 1'b0); send(1, 8'hD2, 1'b1); present();
        wait_drain("contend", 400);

        // fairness: 8 one-byte messages alternate 0,1,0,1...
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send(0, 8'(8'hE0 + i), 1'b1);
            send(1, 8'(8'hF0 + i), 1'b1);
        end
        present();
        wait_drain("fair", 600);

        // source 1 drops request after 2nd byte; source 0 waiting
        @(negedge clk);
        send(1, 8'h31, 1'b0); send(1, 8'h32, 1'b0); present();
        t = 0;
        while (grant != 2'b10 && t < 20) begin @(negedge clk); t++; end
        chk("drop_owner1", 32'(grant), 2);
        send(0, 8'h30, 1'b1); present();
        wait_drain("drop", 300);

`ifdef UART_TX_ARB_TIMEOUT_EN
        @(negedge clk);
        withhold = 1'b1;
        send(1, 8'h77, 1'b1); present();
        t = 0;
        while (!tmo && t < 300) begin @(negedge clk); t++; end
        chk("tmo_seen",  32'(tmo), 1);
        chk("tmo_lat",   cyc - last_dv_cyc, TMO);
        chk("tmo_grant", 32'(grant), 0);
        @(negedge clk);
        chk("tmo_pulse", 32'(tmo), 0);
        withhold = 1'b0;
        repeat (20) @(negedge clk);
        chk("tmo_count", n_tmo, 1);
        chk("tmo_sb",    32'(exp_q.size()), 0);
`else
        chk("tmo_none", n_tmo, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
